// File: rtl/snoop_grant_ctl_if.sv
// Handshake bundle between the tag tree root / snooper (master) and snoop_grant_ctl (slave).
interface snoop_grant_ctl_if #(
    parameter int TAG_SZ   = 5,
    parameter int NUM_BUFS = 32,
    parameter int CNT_W    = 16
);
    logic [TAG_SZ-1:0]   tag;
    logic                rdy;
    logic                ack;
    logic                sn_sop;
    logic                sn_eop;
    logic [TAG_SZ-1:0]   grant_tag;
    logic                grant_vld;
    logic [NUM_BUFS-1:0] buf_done;
    logic                drop;
    logic [CNT_W-1:0]    drop_cnt;

    modport master (
        output tag, rdy, sn_sop, sn_eop,
        input  ack, grant_tag, grant_vld, buf_done, drop, drop_cnt
    );

    modport slave (
        input  tag, rdy, sn_sop, sn_eop,
        output ack, grant_tag, grant_vld, buf_done, drop, drop_cnt
    );
endinterface

// File: rtl/snoop_grant_ctl.sv
// Binds a free buffer tag from the tag tree root to the next snooped packet and strobes buf_done at EOP.
// Optional saturating drop counter enabled by defining SNOOP_GRANT_DROP_CNT_EN.
module snoop_grant_ctl #(
    parameter int TAG_SZ   = 5,
    parameter int NUM_BUFS = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    snoop_grant_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRIMED,
        BUSY,
        DROPPING
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_SZ-1:0]   grant_tag_q, grant_tag_d;
    logic                grant_vld_q, grant_vld_d;
    logic [NUM_BUFS-1:0] buf_done_q, buf_done_d;
    logic                drop_q, drop_d;
    logic [NUM_BUFS-1:0] done_onehot;
    logic                release_buf;

    // A start-of-packet in IDLE must win over the pop, so it also masks ack.
    assign bus.ack = (state_q == IDLE) && !bus.sn_sop && !rst;

    // Tags beyond NUM_BUFS simply match no bit and release nothing.
    always_comb begin
        done_onehot = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            done_onehot[i] = (grant_tag_q == TAG_SZ'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_tag_d = grant_tag_q;
        grant_vld_d = grant_vld_q;
        drop_d      = 1'b0;
        release_buf = 1'b0;
        buf_done_d  = '0;

        case (state_q)
            IDLE: begin
                if (bus.sn_sop) begin
                    drop_d  = 1'b1;
                    state_d = bus.sn_eop ? IDLE : DROPPING;
                end else if (bus.rdy) begin
                    grant_tag_d = bus.tag;
                    grant_vld_d = 1'b1;
                    state_d     = PRIMED;
                end
            end
            PRIMED: begin
                if (bus.sn_sop && bus.sn_eop) begin
                    release_buf = 1'b1;
                    state_d     = IDLE;
                end else if (bus.sn_sop) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.sn_eop) begin
                    release_buf = 1'b1;
                    state_d     = IDLE;
                end
            end
            DROPPING: begin
                if (bus.sn_eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_buf) begin
            grant_vld_d = 1'b0;
            buf_done_d  = done_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_tag_q <= '0;
            grant_vld_q <= 1'b0;
            buf_done_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_tag_q <= grant_tag_d;
            grant_vld_q <= grant_vld_d;
            buf_done_q  <= buf_done_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.grant_tag = grant_tag_q;
    assign bus.grant_vld = grant_vld_q;
    assign bus.buf_done  = buf_done_q;
    assign bus.drop      = drop_q;

`ifdef SNOOP_GRANT_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Counts on drop_d so the new value appears alongside the drop pulse.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = '0;
`endif

endmodule
